mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS datapath. Decodes IR fields, steps through FETCH/DECODE/EXEC/MEM/WB.
//  Drives the write enables and the select inputs of the datapath muxes:
//   - regdst_sel -> 5-bit 4:1 mux
//   - alub_sel   -> 32-bit 2:1 mux
//   - wdsel      -> 32-bit 8:1 mux
//  Also drives the ALU/EXT/NPC controls. Sits between IR and the shared PC/IR/GRF/DM/ALU datapath.
// PARAMETERS
//  CNT_W  32  width of the retired-instruction counter instr_cnt
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  opcode      in   6      IR[31:26]
//  funct       in   6      IR[5:0]
//  zero        in   1      ALU equal flag (valid in EXEC)
//  pc_we       out  1      PC register write enable
//  ir_we       out  1      IR write enable
//  grf_we      out  1      register file write enable
//  mem_we      out  1      data memory write enable
//  regdst_sel  out  2      0=rt 1=rd 2=5'd31 (3 unused)
//  alub_sel    out  1      0=GRF rt data 1=EXT output
//  wdsel       out  3      0=ALU 1=DM 2=PC (link); 3..7 unused, never driven
//  ext_op      out  2      0=zero-ext 1=sign-ext 2=imm<<16
//  alu_op      out  3      0=add 1=sub 2=or (3..7 unused)
//  npc_sel     out  2      0=PC+4 1=branch 2=j/jal target 3=GRF[rs]
//  state       out  3      current state, for debug
//  instr_cnt   out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  State encoding: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4. Codes 5..7 return to FETCH on the next edge, no enables.
//  Reset (reset=0), applied asynchronously and immediately:
//   - state=FETCH, instr_cnt=0.
//   - All *_we=0 for as long as reset is low; the FSM is frozen.
//   - Every select output is 0.
//  Reset mid-instruction: the instruction is abandoned. The first rising edge after release executes FETCH.
//  Outputs are combinational from state+opcode+funct+zero. Non-enable selects are 0 unless listed below.
//  Supported: addu subu (R, funct 21/23), ori(0d), lw(23), sw(2b), beq(04), lui(0f), j(02), jal(03), jr (R, funct 08).
//  Any other opcode/funct, including sll $0 (nop), is a NOP.
//  FETCH:
//   - ir_we=1, pc_we=1, npc_sel=0.
//   - Next state: DECODE.
//  DECODE:
//   - j: pc_we=1 npc_sel=2, then FETCH.
//   - jr: pc_we=1 npc_sel=3, then FETCH.
//   - jal: pc_we=1 npc_sel=2 grf_we=1 regdst_sel=2 wdsel=2, then FETCH. PC already holds PC+4, so that value is linked.
//   - NOP: no enables, then FETCH.
//   - Otherwise: EXEC.
//  EXEC: no enables except beq.
//   - addu: alu_op=0, alub_sel=0.
//   - subu: alu_op=1, alub_sel=0.
//   - ori: alu_op=2, alub_sel=1, ext_op=0.
//   - lw/sw: alu_op=0, alub_sel=1, ext_op=1.
//   - lui: alu_op=0, alub_sel=1, ext_op=2 (ALU A is $0 via rs).
//   - beq: alu_op=1, alub_sel=0. pc_we=zero, npc_sel=1, ext_op=1. Next state FETCH.
//   - Next state: lw/sw -> MEM; all others -> WB.
//  MEM: ALU inputs held as in EXEC.
//   - sw: mem_we=1, then FETCH.
//   - lw: no enables, then WB.
//  WB: grf_we=1, then FETCH.
//   - regdst_sel=1 for R-type, 0 otherwise.
//   - wdsel=1 for lw, 0 otherwise.
//   - EXEC selects held.
//  Cycle counts: j/jr/jal/nop 2, beq 3, R/ori/lui/sw 4, lw 5.
//  instr_cnt increments by 1 on every edge whose next state is FETCH, entered from a non-FETCH state.
//   - Wraps modulo 2^CNT_W.
//   - Invalid state codes 5..7 do not count.
//  At most one of mem_we/grf_we is high in any cycle, except jal in DECODE (grf_we+pc_we).
//  opcode/funct must be stable from DECODE onward; IR only changes in FETCH.
// TESTING
//  1. Hold reset=0 for 3 cycles: all *_we=0, state=0, instr_cnt=0. Release: FETCH with ir_we=pc_we=1.
//  2. addu (op 00, funct 21): states 0,1,2,4,0. WB cycle shows grf_we=1 regdst_sel=1 wdsel=0. instr_cnt=1.
//  3. lw then sw:
//     - lw walks 0,1,2,3,4 with wdsel=1 in WB.
//     - sw walks 0,1,2,3 with mem_we=1 only in MEM.
//     - instr_cnt=2 after both.
//  4. beq with zero=1, then with zero=0:
//     - pc_we=1 npc_sel=1 in EXEC for the first case only.
//     - Both return to FETCH after 3 cycles.
//  5. jal (op 03): DECODE shows pc_we=1 grf_we=1 regdst_sel=2 wdsel=2 npc_sel=2. jr: npc_sel=3.
//     Illegal op 3f: 2 cycles, no enables after FETCH.
//  6. Pull reset low asynchronously mid-lw (in MEM):
//     - Enables drop before the next edge; state=0 and instr_cnt=0 immediately.
//     - After release, FETCH runs.
//     Preload instr_cnt near 2^CNT_W-1 (CNT_W=4 build) and verify the wrap to 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: walks FETCH/DECODE/EXEC/MEM/WB and drives
// the datapath enables, mux selects and ALU/EXT/NPC controls from the IR fields.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_we,
    output logic             ir_we,
    output logic             grf_we,
    output logic             mem_we,
    output logic [1:0]       regdst_sel,
    output logic             alub_sel,
    output logic [2:0]       wdsel,
    output logic [1:0]       ext_op,
    output logic [2:0]       alu_op,
    output logic [1:0]       npc_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] instr_cnt_reg;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
    logic is_beq, is_lui, is_j, is_jal, is_nop;
    logic pc_en, ir_en, grf_en, mem_en;

    assign is_r    = (opcode == 6'h00);
    assign is_addu = is_r && (funct == 6'h21);
    assign is_subu = is_r && (funct == 6'h23);
    assign is_jr   = is_r && (funct == 6'h08);
    assign is_ori  = (opcode == 6'h0d);
    assign is_lw   = (opcode == 6'h23);
    assign is_sw   = (opcode == 6'h2b);
    assign is_beq  = (opcode == 6'h04);
    assign is_lui  = (opcode == 6'h0f);
    assign is_j    = (opcode == 6'h02);
    assign is_jal  = (opcode == 6'h03);
    assign is_nop  = !(is_addu || is_subu || is_jr || is_ori || is_lw || is_sw ||
                       is_beq || is_lui || is_j || is_jal);

    always_comb begin
        state_next = S_FETCH;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        grf_en     = 1'b0;
        mem_en     = 1'b0;
        regdst_sel = 2'd0;
        alub_sel   = 1'b0;
        wdsel      = 3'd0;
        ext_op     = 2'd0;
        alu_op     = 3'd0;
        npc_sel    = 2'd0;
        case (state_reg)
            S_FETCH: begin
                ir_en      = 1'b1;
                pc_en      = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_en   = 1'b1;
                    npc_sel = 2'd2;
                end else if (is_jr) begin
                    pc_en   = 1'b1;
                    npc_sel = 2'd3;
                end else if (is_jal) begin
                    // PC already advanced in FETCH, so wdsel=2 links PC+4
                    pc_en      = 1'b1;
                    npc_sel    = 2'd2;
                    grf_en     = 1'b1;
                    regdst_sel = 2'd2;
                    wdsel      = 3'd2;
                end else if (!is_nop) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC, S_MEM, S_WB: begin
                // ALU/EXT selects stay constant from EXEC through WB
                if (is_subu || is_beq) alu_op = 3'd1;
                if (is_ori)            alu_op = 3'd2;
                alub_sel = is_ori || is_lw || is_sw || is_lui;
                if (is_lw || is_sw || is_beq) ext_op = 2'd1;
                if (is_lui)                   ext_op = 2'd2;
                if (state_reg == S_EXEC) begin
                    if (is_beq) begin
                        pc_en      = zero;
                        npc_sel    = 2'd1;
                        state_next = S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state_next = S_MEM;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (state_reg == S_MEM) begin
                    if (is_sw) begin
                        mem_en = 1'b1;
                    end else if (is_lw) begin
                        state_next = S_WB;
                    end
                end else begin
                    grf_en     = 1'b1;
                    regdst_sel = is_r ? 2'd1 : 2'd0;
                    wdsel      = is_lw ? 3'd1 : 3'd0;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_FETCH;
            instr_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next == S_FETCH &&
                (state_reg == S_DECODE || state_reg == S_EXEC ||
                 state_reg == S_MEM || state_reg == S_WB))
                instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
        end
    end

    // Enables are masked by reset so they drop before the next edge
    assign pc_we     = pc_en  & reset;
    assign ir_we     = ir_en  & reset;
    assign grf_we    = grf_en & reset;
    assign mem_we    = mem_en & reset;
    assign state     = state_reg;
    assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes per-cycle expected outputs
// from an instruction-level model; a negedge monitor pops and compares.
module tb_mc_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    opcode = 6'h00;
    logic [5:0]    funct = 6'h00;
    logic          zero = 1'b0;
    logic          pc_we, ir_we, grf_we, mem_we;
    logic [1:0]    regdst_sel;
    logic          alub_sel;
    logic [2:0]    wdsel;
    logic [1:0]    ext_op;
    logic [2:0]    alu_op;
    logic [1:0]    npc_sel;
    logic [2:0]    state;
    logic [CW-1:0] instr_cnt;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .grf_we(grf_we), .mem_we(mem_we),
        .regdst_sel(regdst_sel), .alub_sel(alub_sel), .wdsel(wdsel),
        .ext_op(ext_op), .alu_op(alu_op), .npc_sel(npc_sel),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pc, ir, grf, mem;
        logic [1:0]    regdst;
        logic          alub;
        logic [2:0]    wd;
        logic [1:0]    ext;
        logic [2:0]    alu;
        logic [1:0]    npc;
        logic [2:0]    st;
        logic [CW-1:0] cnt;
    } obs_t;

    typedef enum int {ADDU, SUBU, ORI, LW, SW, BEQ, LUI, J, JAL, JR, NOP} cls_t;

    obs_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   model_cnt = 0;
    int   wraps = 0;

    function automatic string cname(cls_t c);
        return c.name();
    endfunction

    // Cycle count per instruction class
    function automatic int ilen(cls_t c);
        case (c)
            J, JR, JAL, NOP: return 2;
            BEQ:             return 3;
            LW:              return 5;
            default:         return 4;
        endcase
    endfunction

    // State visited in cycle k; ALU-only instructions skip MEM
    function automatic int st_at(cls_t c, int k);
        if ((c == ADDU || c == SUBU || c == ORI || c == LUI) && k == 3) return 4;
        return k;
    endfunction

    function automatic obs_t expect_cycle(cls_t c, int k, bit z, int cnt);
        obs_t e;
        int   s;
        e = '0;
        s = st_at(c, k);
        e.st  = 3'(s);
        e.cnt = CW'(cnt);
        if (s == 0) begin
            e.pc = 1; e.ir = 1;
        end else if (s == 1) begin
            if (c == J)   begin e.pc = 1; e.npc = 2; end
            if (c == JR)  begin e.pc = 1; e.npc = 3; end
            if (c == JAL) begin e.pc = 1; e.npc = 2; e.grf = 1; e.regdst = 2; e.wd = 2; end
        end else begin
            case (c)
                SUBU:   e.alu = 1;
                ORI:    begin e.alu = 2; e.alub = 1; end
                LW, SW: begin e.alub = 1; e.ext = 1; end
                LUI:    begin e.alub = 1; e.ext = 2; end
                BEQ:    begin e.alu = 1; e.ext = 1; e.npc = 1; e.pc = z; end
                default: ;
            endcase
            if (s == 3 && c == SW) e.mem = 1;
            if (s == 4) begin
                e.grf = 1;
                e.regdst = (c == ADDU || c == SUBU) ? 2'd1 : 2'd0;
                e.wd = (c == LW) ? 3'd1 : 3'd0;
            end
        end
        return e;
    endfunction

    task automatic encode(cls_t c, output logic [5:0] op, output logic [5:0] fn);
        int r;
        fn = 6'($urandom);
        case (c)
            ADDU: begin op = 6'h00; fn = 6'h21; end
            SUBU: begin op = 6'h00; fn = 6'h23; end
            JR:   begin op = 6'h00; fn = 6'h08; end
            ORI:  op = 6'h0d;
            LW:   op = 6'h23;
            SW:   op = 6'h2b;
            BEQ:  op = 6'h04;
            LUI:  op = 6'h0f;
            J:    op = 6'h02;
            JAL:  op = 6'h03;
            default: begin
                r = $urandom_range(0, 3);
                case (r)
                    0: begin op = 6'h3f; end
                    1: begin op = 6'h00; fn = 6'h00; end
                    2: begin op = 6'h20; end
                    default: begin op = 6'h00; fn = 6'h2a; end
                endcase
            end
        endcase
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // abort_k >= 0: pull reset low asynchronously inside that cycle
    task automatic run_instr(cls_t c, bit z, bit release_rst, int abort_k);
        logic [5:0] op, fn;
        int n;
        encode(c, op, fn);
        n = ilen(c);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (release_rst && k == 0) reset = 1'b1;
            opcode = op;
            funct  = fn;
            zero   = (c == BEQ) ? z : 1'($urandom);
            if (k == abort_k) begin
                #2 reset = 1'b0;
                #1;
                check("async_rst_we", {28'd0, pc_we, ir_we, grf_we, mem_we}, 32'd0);
                check("async_rst_state", {29'd0, state}, 32'd0);
                check("async_rst_cnt", {28'd0, instr_cnt}, 32'd0);
                model_cnt = 0;
                q.push_back('0);
                return;
            end
            q.push_back(expect_cycle(c, k, z, model_cnt));
        end
        $display("instr %s op=%h fn=%h z=%0d cnt=%0d", cname(c), op, fn, z, model_cnt);
        if (model_cnt == (1 << CW) - 1) wraps++;
        model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    task automatic reset_cycles(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            q.push_back('0);
        end
    endtask

    // Monitor: one comparison per sampled cycle
    initial begin
        obs_t got, exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() != 0) begin
                exp = q.pop_front();
                got = {pc_we, ir_we, grf_we, mem_we, regdst_sel, alub_sel, wdsel,
                       ext_op, alu_op, npc_sel, state, instr_cnt};
                checks++;
                if (got === exp) passes++;
                else $display("FAIL cycle%0d outputs: got %h expected %h", cyc, got, exp);
            end
        end
    end

    initial begin
        cls_t c;
        model_cnt = 0;
        reset_cycles(3);
        run_instr(ADDU, 1'b0, 1'b1, -1);
        run_instr(LW,   1'b0, 1'b0, -1);
        run_instr(SW,   1'b0, 1'b0, -1);
        run_instr(BEQ,  1'b1, 1'b0, -1);
        run_instr(BEQ,  1'b0, 1'b0, -1);
        run_instr(JAL,  1'b0, 1'b0, -1);
        run_instr(JR,   1'b0, 1'b0, -1);
        run_instr(NOP,  1'b0, 1'b0, -1);
        run_instr(LW,   1'b0, 1'b0, 3);
        reset_cycles(1);
        run_instr(ORI,  1'b0, 1'b1, -1);
        for (int i = 0; i < 60; i++) begin
            c = cls_t'($urandom_range(0, 10));
            run_instr(c, 1'($urandom), 1'b0, -1);
        end
        @(posedge clk);
        #6;
        check("queue_drained", q.size(), 32'd0);
        check("counter_wrapped", {31'd0, wraps >= 2}, 32'd1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
